// File: rtl/conv_encoder_punct.sv
// Rate-1/2 convolutional encoder with 1/2, 2/3 and 3/4 puncturing, tail insertion,
// and an OUT_W-bit packer with valid/ready handshakes on both sides.
module conv_encoder_punct #(
    parameter int unsigned    IN_W  = 4,
    parameter int unsigned    OUT_W = 8,
    parameter int unsigned    K     = 7,
    parameter logic [K-1:0]   G0    = 7'o133,
    parameter logic [K-1:0]   G1    = 7'o171
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned BUF_W  = OUT_W + 2 * IN_W;
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);
    localparam int unsigned CNT_W  = $clog2(2 * IN_W + 1);
    localparam int unsigned NB_W   = $clog2(IN_W + 1);
    localparam int unsigned TAIL_W = $clog2(K);

    typedef enum logic [1:0] {StIdle, StRun, StTail, StPad} state_e;

    state_e             state_q, state_d;
    logic [K-2:0]       sreg_q, sreg_d, sreg_enc, s;
    logic [1:0]         phase_q, phase_d, phase_enc, ph;
    logic [1:0]         mode_q, eff_mode, period;
    logic [BUF_W-1:0]   acc_q, acc_d, new_bits;
    logic [FILL_W-1:0]  fill_q, fill_d, eff_fill, fill_left;
    logic [TAIL_W-1:0]  tail_q, tail_d;
    logic [NB_W-1:0]    n_bits;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    src;
    logic [K-1:0]       v;
    logic               a_bit, b_bit;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q, out_last_q;
    logic               drain, space, accept, tail_go, last_word;

    // Padding is applied combinationally: in PAD a partial word counts as a full one.
    always_comb begin
        eff_fill = fill_q;
        if (state_q == StPad && fill_q != '0 && fill_q < FILL_W'(OUT_W)) begin
            eff_fill = FILL_W'(OUT_W);
        end
        drain     = (eff_fill >= FILL_W'(OUT_W)) && (!out_valid_q || out_ready);
        fill_left = drain ? eff_fill - FILL_W'(OUT_W) : eff_fill;
        space     = fill_left < FILL_W'(OUT_W);
        in_ready  = en && (state_q == StIdle || state_q == StRun) && space;
        accept    = in_ready && in_valid;
        tail_go   = en && (state_q == StTail) && space;
        last_word = drain && (state_q == StPad) && (fill_q <= FILL_W'(OUT_W));
    end

    always_comb begin
        eff_mode = (state_q == StIdle) ? mode : mode_q;
        case (eff_mode)
            2'd1:    period = 2'd2;
            2'd2:    period = 2'd3;
            default: period = 2'd1;
        endcase
        n_bits = '0;
        src    = '0;
        if (accept) begin
            n_bits = NB_W'(IN_W);
            src    = in_data;
        end else if (tail_go) begin
            n_bits = (32'(tail_q) < IN_W) ? NB_W'(tail_q) : NB_W'(IN_W);
        end
        s        = sreg_q;
        ph       = phase_q;
        v        = '0;
        a_bit    = 1'b0;
        b_bit    = 1'b0;
        new_bits = '0;
        cnt      = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i < int'(n_bits)) begin
                v     = {src[i], s};
                a_bit = ^(v & G0);
                b_bit = ^(v & G1);
                s     = v[K-1:1];
                // phase 1 drops B, phase 2 drops A
                if (ph != 2'd2) begin
                    new_bits = new_bits | (BUF_W'(a_bit) << cnt);
                    cnt      = cnt + CNT_W'(1);
                end
                if (ph != 2'd1) begin
                    new_bits = new_bits | (BUF_W'(b_bit) << cnt);
                    cnt      = cnt + CNT_W'(1);
                end
                ph = (ph + 2'd1 == period) ? 2'd0 : ph + 2'd1;
            end
        end
        sreg_enc  = s;
        phase_enc = ph;
    end

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        sreg_d  = sreg_enc;
        phase_d = phase_enc;
        acc_d   = (drain ? acc_q >> OUT_W : acc_q) | (new_bits << fill_left);
        fill_d  = fill_left + FILL_W'(cnt);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = flush ? StTail : StRun;
                    tail_d  = TAIL_W'(K - 1);
                end
            end
            StRun: begin
                if (en && flush) begin
                    state_d = StTail;
                    tail_d  = TAIL_W'(K - 1);
                end
            end
            StTail: begin
                if (tail_go) begin
                    tail_d = tail_q - TAIL_W'(n_bits);
                    if (tail_d == '0) state_d = StPad;
                end
            end
            StPad: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = StIdle;
                    sreg_d  = '0;
                    phase_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            phase_q     <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            tail_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            if (accept && state_q == StIdle) mode_q <= mode;
            if (drain) begin
                out_data_q  <= acc_q[OUT_W-1:0];
                out_valid_q <= 1'b1;
                out_last_q  <= last_word;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: impulse responses per rate, backpressure,
// mid-packet mode change and mid-packet reset, checked with immediate assertions.
module tb_conv_encoder_punct;

    logic       clk, reset, en, in_valid, in_ready, flush;
    logic       out_valid, out_ready, out_last, busy;
    logic [1:0] mode;
    logic [3:0] in_data;
    logic [7:0] out_data;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_cnt = 0;
    bit   acc_seen, toggle, held_v;
    logic [8:0] held_w;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    bit   info[$];
    logic [3:0] d;

    conv_encoder_punct #(
        .IN_W (4),
        .OUT_W(8),
        .K    (7),
        .G0   (7'o133),
        .G1   (7'o171)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge (collect words, check stall stability), drive after posedge.
    task automatic tick();
        @(negedge clk);
        if (in_valid && !in_ready) stall_cnt++;
        acc_seen = in_valid && in_ready;
        if (held_v && reset) chk("hold_stable", 32'({out_valid, out_last, out_data}),
                                 32'({1'b1, held_w}));
        held_v = out_valid && !out_ready;
        held_w = {out_last, out_data};
        if (out_valid && out_ready) got.push_back({out_last, out_data});
        @(posedge clk);
        #1;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [3:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_seen && n < 200);
        in_valid = 1'b0;
        chk("send_accept", 32'(acc_seen), 32'd1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_pkt(input string tag, input logic [8:0] expw[$]);
        chk({tag, "_words"}, 32'(got.size()), 32'(expw.size()));
        for (int i = 0; i < expw.size() && i < got.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(expw[i]));
        end
    endtask

    // Bit-serial reference: encode, puncture, pad, pack LSB-first; bit 8 marks the last word.
    task automatic model(input int md, input bit bits_in[$], output logic [8:0] words[$]);
        bit         coded[$];
        logic [5:0] s;
        logic [6:0] v;
        logic [7:0] w;
        bit         u, a, b;
        int         ph, per, nw;
        s = '0;
        ph = 0;
        per = (md == 1) ? 2 : ((md == 2) ? 3 : 1);
        words.delete();
        for (int i = 0; i < bits_in.size() + 6; i++) begin
            u = (i < bits_in.size()) ? bits_in[i] : 1'b0;
            v = {u, s};
            a = ^(v & 7'o133);
            b = ^(v & 7'o171);
            s = v[6:1];
            if (ph != 2) coded.push_back(a);
            if (ph != 1) coded.push_back(b);
            ph = (ph + 1) % per;
        end
        while (coded.size() % 8 != 0) coded.push_back(1'b0);
        nw = coded.size() / 8;
        for (int j = 0; j < nw; j++) begin
            for (int k = 0; k < 8; k++) w[k] = coded[8 * j + k];
            words.push_back({(j == nw - 1), w});
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; mode = 2'd0; in_data = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b1; toggle = 1'b0; held_v = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        en = 1'b0;
        #1 chk("en0_in_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Rate 1/2 impulse
        got.delete(); mode = 2'd0;
        send(4'b0001); do_flush(); wait_idle("r12");
        exp_q = '{9'h0FB, 9'h034, 9'h100};
        chk_pkt("r12", exp_q);

        // Rate 2/3 impulse
        got.delete(); mode = 2'd1;
        send(4'b0001); do_flush(); wait_idle("r23");
        exp_q = '{9'h03B, 9'h107};
        chk_pkt("r23", exp_q);

        // Rate 3/4 impulse
        got.delete(); mode = 2'd2;
        send(4'b0001); do_flush(); wait_idle("r34");
        exp_q = '{9'h03B, 9'h103};
        chk_pkt("r34", exp_q);

        // Backpressure with random data
        got.delete(); info.delete(); mode = 2'd0; stall_cnt = 0; toggle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 4'($urandom);
            for (int k = 0; k < 4; k++) info.push_back(d[k]);
            send(d);
        end
        do_flush(); wait_idle("bp");
        toggle = 1'b0; out_ready = 1'b1; held_v = 1'b0;
        model(0, info, exp_q);
        chk_pkt("bp", exp_q);
        chk("bp_in_ready_drop", 32'(stall_cnt > 0), 32'd1);

        // Mode change mid-packet is ignored; next packet uses the new mode
        got.delete(); info.delete(); mode = 2'd0;
        d = 4'hB; for (int k = 0; k < 4; k++) info.push_back(d[k]);
        send(d);
        mode = 2'd2;
        d = 4'h6; for (int k = 0; k < 4; k++) info.push_back(d[k]);
        send(d);
        do_flush(); wait_idle("mc");
        model(0, info, exp_q);
        chk_pkt("mc", exp_q);
        got.delete();
        send(4'b0001); do_flush(); wait_idle("mc2");
        exp_q = '{9'h03B, 9'h103};
        chk_pkt("mc2", exp_q);

        // Reset mid-packet
        got.delete(); mode = 2'd0;
        send(4'h5); send(4'hA); send(4'h3);
        #1 chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_out_last", 32'(out_last), 32'd0);
        held_v = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        got.delete();
        send(4'b0001); do_flush(); wait_idle("rst_imp");
        exp_q = '{9'h0FB, 9'h034, 9'h100};
        chk_pkt("rst_imp", exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
